// File: rtl/reg_file_pkg.sv
// Shared CPU datapath constants: architectural register indices, write-back
// select encodings and the default datapath widths used by writeback and decode.
package reg_file_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

endpackage

// File: rtl/reg_file_bypass.sv
// One read port of the register file. It applies the zero-register rule and
// forwards an in-flight write-back value to the reader in the same cycle.
module reg_bypass #(
    parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH
) (
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_reg,
    input  logic [DATA_WIDTH-1:0] stored_data,
    output logic [DATA_WIDTH-1:0] read_data
);
    import reg_file_pkg::*;

    always_comb begin
        // NOTE: every path of this block assigns read_data because of the
        // default on the first line; without it, synthesis would infer a latch.
        read_data = stored_data;
        if (read_reg == '0) begin
            read_data = '0;
        end else if (!reset && RegWrite && (write_reg == read_reg)) begin
            read_data = write_data;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file: 2^ADDR_WIDTH flop-based entries, one write-back
// write per cycle, two bypassed combinational read ports and one raw debug port.
module reg_file #(
    parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    input  logic [ADDR_WIDTH-1:0] dbg_reg,
    output logic [DATA_WIDTH-1:0] dbg_data
);
    import reg_file_pkg::*;

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    // Entry 0 is never a write target, so it holds the zero from reset forever.
    always_comb begin
        regs_d = regs_q;
        if (RegWrite && (write_reg != '0)) begin
            regs_d[write_reg] = write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: this array is plain flops rather than a RAM macro, so it
            // can and must be cleared: after reset every register reads zero.
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignment, so all entries take their
            // next-state value together at the edge.
            regs_q <= regs_d;
        end
    end

    reg_bypass #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bypass_rs (
        .reset       (reset),
        .RegWrite    (RegWrite),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .read_reg    (read_reg1),
        .stored_data (regs_q[read_reg1]),
        .read_data   (read_data1)
    );

    reg_bypass #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bypass_rt (
        .reset       (reset),
        .RegWrite    (RegWrite),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .read_reg    (read_reg2),
        .stored_data (regs_q[read_reg2]),
        .read_data   (read_data2)
    );

    // Debug port shows committed state only, never the in-flight write.
    assign dbg_data = (dbg_reg == '0) ? '0 : regs_q[dbg_reg];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus a short random run,
// with expected values queued at drive time and compared at the sampling edge.
module tb_reg_file;

    localparam int DW = 32;
    localparam int AW = 5;

    localparam logic [1:0] SEL_RD1 = 2'd0;
    localparam logic [1:0] SEL_RD2 = 2'd1;
    localparam logic [1:0] SEL_DBG = 2'd2;

    logic          clk = 1'b0;
    logic          reset;
    logic          RegWrite;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic [AW-1:0] read_reg1;
    logic [AW-1:0] read_reg2;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] read_data2;
    logic [AW-1:0] dbg_reg;
    logic [DW-1:0] dbg_data;

    int checks = 0;
    int errors = 0;

    string         tag_q [$];
    logic [1:0]    sel_q [$];
    logic [DW-1:0] val_q [$];

    logic [DW-1:0] model [32];

    always #5 clk = ~clk;

    reg_file dut (
        .clk        (clk),
        .reset      (reset),
        .RegWrite   (RegWrite),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .dbg_reg    (dbg_reg),
        .dbg_data   (dbg_data)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [1:0] sel, input logic [DW-1:0] val);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        val_q.push_back(val);
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic drive(input logic rst, input logic we, input logic [AW-1:0] wreg,
                         input logic [DW-1:0] wdata, input logic [AW-1:0] r1,
                         input logic [AW-1:0] r2, input logic [AW-1:0] dbg);
        @(posedge clk);
        #1;
        reset      = rst;
        RegWrite   = we;
        write_reg  = wreg;
        write_data = wdata;
        read_reg1  = r1;
        read_reg2  = r2;
        dbg_reg    = dbg;
    endtask

    // Outputs are compared on the falling edge, mid-cycle.
    task automatic sample();
        logic [DW-1:0] obs;
        @(negedge clk);
        while (tag_q.size() > 0) begin
            string      t;
            logic [1:0] s;
            logic [DW-1:0] v;
            t = tag_q.pop_front();
            s = sel_q.pop_front();
            v = val_q.pop_front();
            case (s)
                SEL_RD1: obs = read_data1;
                SEL_RD2: obs = read_data2;
                default: obs = dbg_data;
            endcase
            check(t, obs, v);
        end
    endtask

    task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic [AW-1:0] dbg);
        drive(1'b0, 1'b0, '0, '0, r1, r2, dbg);
    endtask

    task automatic write(input logic [AW-1:0] wreg, input logic [DW-1:0] wdata);
        drive(1'b0, 1'b1, wreg, wdata, '0, '0, '0);
    endtask

    initial begin
        reset      = 1'b0;
        RegWrite   = 1'b0;
        write_reg  = '0;
        write_data = '0;
        read_reg1  = '0;
        read_reg2  = '0;
        dbg_reg    = '0;

        // Reset then sweep every entry on all three read paths.
        drive(1'b1, 1'b0, '0, '0, '0, '0, '0);
        for (int i = 0; i < 32; i++) begin
            idle(AW'(i), AW'(i), AW'(i));
            expect_out($sformatf("rst_dbg_%0d", i), SEL_DBG, '0);
            expect_out($sformatf("rst_rd1_%0d", i), SEL_RD1, '0);
            expect_out($sformatf("rst_rd2_%0d", i), SEL_RD2, '0);
            sample();
        end

        // Basic write then read.
        drive(1'b0, 1'b1, 5'd8, 32'hDEADBEEF, 5'd8, 5'd0, 5'd8);
        expect_out("wr8_bypass_rd1", SEL_RD1, 32'hDEADBEEF);
        expect_out("wr8_dbg_before", SEL_DBG, 32'h0);
        sample();
        idle(5'd8, 5'd0, 5'd8);
        expect_out("rd8_rd1", SEL_RD1, 32'hDEADBEEF);
        expect_out("rd8_dbg", SEL_DBG, 32'hDEADBEEF);
        sample();
        drive(1'b0, 1'b1, 5'd31, 32'h0000_0004, 5'd0, 5'd0, 5'd31);
        expect_out("wr31_dbg_before", SEL_DBG, 32'h0);
        sample();
        idle(5'd0, 5'd31, 5'd31);
        expect_out("rd31_dbg", SEL_DBG, 32'h4);
        expect_out("rd31_rd2", SEL_RD2, 32'h4);
        sample();

        // Zero register ignores writes and never bypasses.
        drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        expect_out("zero_same_rd1", SEL_RD1, '0);
        expect_out("zero_same_rd2", SEL_RD2, '0);
        expect_out("zero_same_dbg", SEL_DBG, '0);
        sample();
        idle(5'd0, 5'd0, 5'd0);
        expect_out("zero_after_rd1", SEL_RD1, '0);
        expect_out("zero_after_dbg", SEL_DBG, '0);
        sample();

        // Bypass on both ports while committed state still holds the old value.
        write(5'd5, 32'h11);
        drive(1'b0, 1'b1, 5'd5, 32'h22, 5'd5, 5'd5, 5'd5);
        expect_out("byp_rd1", SEL_RD1, 32'h22);
        expect_out("byp_rd2", SEL_RD2, 32'h22);
        expect_out("byp_dbg_old", SEL_DBG, 32'h11);
        sample();
        idle(5'd5, 5'd0, 5'd5);
        expect_out("byp_dbg_new", SEL_DBG, 32'h22);
        expect_out("byp_rd1_after", SEL_RD1, 32'h22);
        sample();

        // Reset wins over a simultaneous write, and suppresses the bypass.
        write(5'd3, 32'hA5A5A5A5);
        idle(5'd3, 5'd0, 5'd3);
        expect_out("r3_loaded", SEL_DBG, 32'hA5A5A5A5);
        sample();
        drive(1'b1, 1'b1, 5'd3, 32'h1, 5'd3, 5'd3, 5'd3);
        expect_out("rstwr_no_byp_rd1", SEL_RD1, 32'hA5A5A5A5);
        expect_out("rstwr_no_byp_rd2", SEL_RD2, 32'hA5A5A5A5);
        sample();
        idle(5'd3, 5'd8, 5'd3);
        expect_out("rstwr_r3_dbg", SEL_DBG, '0);
        expect_out("rstwr_r3_rd1", SEL_RD1, '0);
        expect_out("rstwr_r8_rd2", SEL_RD2, '0);
        sample();

        // Back-to-back writes to r7; neighbours stay zero.
        for (int k = 1; k <= 3; k++) begin
            drive(1'b0, 1'b1, 5'd7, DW'(k), 5'd6, 5'd8, 5'd7);
            expect_out($sformatf("b2b_dbg_w%0d", k), SEL_DBG, DW'(k - 1));
            expect_out($sformatf("b2b_r6_w%0d", k), SEL_RD1, '0);
            expect_out($sformatf("b2b_r8_w%0d", k), SEL_RD2, '0);
            sample();
        end
        idle(5'd6, 5'd8, 5'd7);
        expect_out("b2b_dbg_final", SEL_DBG, 32'd3);
        expect_out("b2b_r6_final", SEL_RD1, '0);
        expect_out("b2b_r8_final", SEL_RD2, '0);
        sample();

        // Random traffic against a reference model, starting from a fresh reset.
        drive(1'b1, 1'b0, '0, '0, '0, '0, '0);
        sample();
        for (int i = 0; i < 32; i++) model[i] = '0;
        for (int n = 0; n < 200; n++) begin
            logic          rst;
            logic          we;
            logic [AW-1:0] wr;
            logic [DW-1:0] wd;
            logic [AW-1:0] r1;
            logic [AW-1:0] r2;
            logic [AW-1:0] dr;
            logic [DW-1:0] e1;
            logic [DW-1:0] e2;
            logic [DW-1:0] ed;
            rst = ($urandom_range(0, 15) == 0);
            we  = ($urandom_range(0, 3) != 0);
            wr  = AW'($urandom_range(0, 7));
            wd  = $urandom();
            r1  = ($urandom_range(0, 1) == 0) ? wr : AW'($urandom_range(0, 7));
            r2  = ($urandom_range(0, 1) == 0) ? wr : AW'($urandom_range(0, 7));
            dr  = ($urandom_range(0, 1) == 0) ? wr : AW'($urandom_range(0, 7));

            e1 = (r1 == 0) ? '0 : (!rst && we && wr == r1) ? wd : model[r1];
            e2 = (r2 == 0) ? '0 : (!rst && we && wr == r2) ? wd : model[r2];
            ed = (dr == 0) ? '0 : model[dr];

            drive(rst, we, wr, wd, r1, r2, dr);
            expect_out($sformatf("rnd%0d_rd1_r%0d", n, r1), SEL_RD1, e1);
            expect_out($sformatf("rnd%0d_rd2_r%0d", n, r2), SEL_RD2, e2);
            expect_out($sformatf("rnd%0d_dbg_r%0d", n, dr), SEL_DBG, ed);
            sample();

            if (rst) begin
                for (int i = 0; i < 32; i++) model[i] = '0;
            end else if (we && wr != 0) begin
                model[wr] = wd;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file for the 32-bit MIPS-style datapath, sitting directly downstream of the write-back select `mux`. It holds 32 general-purpose registers, accepts one write per cycle from the write-back stage (`write_data`), and serves two combinational read ports to the decode stage. Register 0 is hard-wired to zero. A write-first bypass lets a register written in cycle N be read in the same cycle N without a forwarding path elsewhere.

## Interface
Parameters:
- `DATA_WIDTH`, default 32, register width in bits.
- `ADDR_WIDTH`, default 5, register index width; depth is 2^ADDR_WIDTH.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high.
- `RegWrite`  input  1  write enable from control, write-back stage.
- `write_reg`  input  ADDR_WIDTH  destination register index.
- `write_data`  input  DATA_WIDTH  value from the write-back select mux.
- `read_reg1`  input  ADDR_WIDTH  read port 1 index (rs).
- `read_reg2`  input  ADDR_WIDTH  read port 2 index (rt).
- `read_data1`  output  DATA_WIDTH  read port 1 data.
- `read_data2`  output  DATA_WIDTH  read port 2 data.
- `dbg_reg`  input  ADDR_WIDTH  debug/bench read index.
- `dbg_data`  output  DATA_WIDTH  debug read data; raw array content, no bypass.

## Operation
- Storage: 2^ADDR_WIDTH × DATA_WIDTH flops; entry 0 is never written and always reads 0.
- Write: on a rising edge with `reset`=0, `RegWrite`=1 and `write_reg`≠0, entry `write_reg` ← `write_data`. `RegWrite`=1 with `write_reg`=0 has no effect.
- Reset: on a rising edge with `reset`=1, every entry ← 0. Reset takes priority over a simultaneous write; the write is discarded.
- Read ports (each independently, combinational):
  - index 0 → 0.
  - else if `reset`=0, `RegWrite`=1 and `write_reg`==index → `write_data` (bypass).
  - else → stored entry.
- Both read ports may address the same register; both return identical values, including the bypassed value.
- `dbg_data` returns the stored entry only, with index 0 → 0. It is never bypassed, so a bench can observe committed state.
- No arithmetic. Data passes through unmodified at full DATA_WIDTH.

## Timing
- Write latency: value committed at the rising edge where the write is accepted; visible on `dbg_data` after that edge.
- Read latency: zero cycles, combinational from index, `RegWrite`, `write_reg` and `write_data`.
- Bypass makes the in-flight write visible on `read_data1`/`read_data2` in the same cycle it is presented, before the edge.
- Output values after reset: all reads return 0 until the first accepted write. `read_data*` may show a bypass value only once `reset` is low.
- Reset asserted mid-stream: writes presented in reset cycles are lost. The first edge with `reset`=0 accepts writes normally.
- Back-to-back writes to the same register: the last one wins, one per edge.

## Structure
- Shared CPU package holds:
  - `REG_ZERO`=5'd0, `REG_RA`=5'd31.
  - write-back select encodings: `WB_ALU`=2'b00, `WB_MEM`=2'b01, `WB_PC4`=2'b10.
  - `DATA_WIDTH`/`ADDR_WIDTH` defaults, shared with the write-back mux and the decode stage.
- One sub-module is natural: `reg_bypass`, instantiated once per read port. It takes index, stored value, `RegWrite`, `write_reg`, `write_data` and `reset`, and returns the read value including the zero-register rule.

## Test plan
- Reset then read: assert `reset` for 1 cycle, then sweep `dbg_reg` 0..31 → every `dbg_data`=0 and `read_data1`/`read_data2`=0.
- Write/read: write 32'hDEADBEEF to r8, next cycle `read_reg1`=8 → `read_data1`=32'hDEADBEEF. Write 32'h0000_0004 to r31 → `dbg_data`(31)=4.
- Zero register: `RegWrite`=1, `write_reg`=0, `write_data`=32'hFFFFFFFF, with `read_reg1`=0 in the same cycle → `read_data1`=0 in that cycle and all later cycles; `dbg_data`(0)=0.
- Bypass: r5 holds 32'h11, then write 32'h22 to r5 with `read_reg1`=`read_reg2`=5 → both read 32'h22 before the edge while `dbg_data`(5)=32'h11; after the edge `dbg_data`(5)=32'h22.
- Reset vs. write: r3=32'hA5A5A5A5; one cycle with `reset`=1, `RegWrite`=1, `write_reg`=3, `write_data`=32'h1 → `read_data1`(3) shows no bypass during that cycle, and after the edge r3=0.
- Back-to-back: write r7=1, 2, 3 on consecutive edges → `dbg_data`(7) follows 1, 2, 3 one cycle after each write, and r6/r8 stay 0.
